reg_f_ctx: RTL and testbench

Parametrised register file with a hardware context stack for nested CALL/RET. It keeps R0 (constant 0), R1 (constant all-ones), R2 (ACC) and NUM_WORK work registers.
- Push saves ACC and the work registers (one frame) into an internal frame memory.
- Pop restores the most recent frame.
- Both are serialised one register per cycle by a small FSM, so the frame memory is a plain single-port RAM.
- The block sits between the decoder/ALU and the PC stack controller in the core datapath.

---
 rtl/reg_f_ctx_if.sv | 47 ++++
 rtl/reg_f_ctx.sv | 214 +++++++++++++++++++++
 tb/tb_reg_f_ctx.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_f_ctx_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_f_ctx_if
//  Purpose  : Port bundle for reg_f_ctx. The master modport drives requests
//             and the slave modport returns read data and status.
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_f_ctx_if #(
    parameter int WIDTH       = 8,
    parameter int NUM_WORK    = 8,
    parameter int STACK_DEPTH = 8
);
    localparam int SIZE = NUM_WORK + 3;
    localparam int AW   = $clog2(SIZE);
    localparam int DW   = $clog2(STACK_DEPTH + 1);

    logic [AW-1:0]    rf_addr_r1;
    logic [WIDTH-1:0] rf_data_out1;
    logic [AW-1:0]    rf_addr_r2;
    logic [WIDTH-1:0] rf_data_out2;
    logic [AW-1:0]    rf_addr_wr;
    logic             rf_data_we;
    logic [WIDTH-1:0] rf_data_in;
    logic             rf_ctx_push;
    logic             rf_ctx_pop;
    logic             rf_ctx_busy;
    logic             rf_ctx_done;
    logic [DW-1:0]    rf_ctx_depth;
    logic             rf_ctx_overflow;
    logic             rf_ctx_underflow;
    logic             rf_acc_zero;

    modport master (
        output rf_addr_r1, rf_addr_r2, rf_addr_wr, rf_data_we, rf_data_in,
               rf_ctx_push, rf_ctx_pop,
        input  rf_data_out1, rf_data_out2, rf_ctx_busy, rf_ctx_done,
               rf_ctx_depth, rf_ctx_overflow, rf_ctx_underflow, rf_acc_zero
    );

    modport slave (
        input  rf_addr_r1, rf_addr_r2, rf_addr_wr, rf_data_we, rf_data_in,
               rf_ctx_push, rf_ctx_pop,
        output rf_data_out1, rf_data_out2, rf_ctx_busy, rf_ctx_done,
               rf_ctx_depth, rf_ctx_overflow, rf_ctx_underflow, rf_acc_zero
    );
endinterface
`default_nettype wire

// File: rtl/reg_f_ctx.sv
`default_nettype none
// ============================================================================
//  Module   : reg_f_ctx
//  Purpose  : Register file (R0=0, R1=all-ones, R2=ACC, work regs) with a
//             hardware context stack; frames move one register per cycle
//             through a single-port RAM. Optional macro RF_CTX_KEEP_EN keeps
//             register contents after a save instead of clearing them.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_f_ctx #(
    parameter int WIDTH       = 8,
    parameter int NUM_WORK    = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    reg_f_ctx_if.slave    rf
);
    localparam int SIZE   = NUM_WORK + 3;
    localparam int NREG   = NUM_WORK + 1;
    localparam int AW     = $clog2(SIZE);
    localparam int DW     = $clog2(STACK_DEPTH + 1);
    localparam int CW     = $clog2(NREG + 1);
    localparam int MDEPTH = STACK_DEPTH * NREG;
    localparam int MAW    = (MDEPTH > 1) ? $clog2(MDEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] work_q [NREG];
    logic [WIDTH-1:0] work_d [NREG];

    logic [WIDTH-1:0] mem [MDEPTH];
    logic [WIDTH-1:0] mem_rdata_q;

    logic             w_mem_we;
    logic             w_mem_re;
    logic [MAW-1:0]   w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic [DW-1:0]    w_frame;
    logic             w_wr_ok;

    function automatic logic [WIDTH-1:0] rd_port(input logic [AW-1:0] a,
                                                 input logic [WIDTH-1:0] regs [NREG]);
        logic [WIDTH-1:0] v;
        v = '0;
        if (a == AW'(1)) begin
            v = '1;
        end
        for (int k = 0; k < NREG; k++) begin
            if (a == AW'(k + 2)) begin
                v = regs[k];
            end
        end
        return v;
    endfunction

    assign rf.rf_data_out1     = rd_port(rf.rf_addr_r1, work_q);
    assign rf.rf_data_out2     = rd_port(rf.rf_addr_r2, work_q);
    assign rf.rf_ctx_busy      = busy_q;
    assign rf.rf_ctx_done      = done_q;
    assign rf.rf_ctx_depth     = depth_q;
    assign rf.rf_ctx_overflow  = ovf_q;
    assign rf.rf_ctx_underflow = unf_q;

    // Bypass lets a same-cycle zero write to ACC raise the flag immediately.
    assign rf.rf_acc_zero = (work_q[0] == '0) ||
                            (rf.rf_data_we && !busy_q &&
                             (rf.rf_addr_wr == AW'(2)) && (rf.rf_data_in == '0));

    assign w_wr_ok = rf.rf_data_we && !busy_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        depth_d     = depth_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        work_d      = work_q;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_mem_wdata = '0;
        w_frame     = (state_q == ST_RESTORE) ? (depth_q - DW'(1)) : depth_q;
        w_mem_addr  = MAW'(32'(w_frame) * 32'(NREG) + 32'(cnt_q));

        if (w_wr_ok) begin
            for (int k = 0; k < NREG; k++) begin
                if (rf.rf_addr_wr == AW'(k + 2)) begin
                    work_d[k] = rf.rf_data_in;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rf.rf_ctx_push && !rf.rf_ctx_pop) begin
                    if (depth_q == DW'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        state_d = ST_SAVE;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end else if (rf.rf_ctx_pop && !rf.rf_ctx_push) begin
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        state_d = ST_RESTORE;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_SAVE: begin
                w_mem_we = 1'b1;
                for (int k = 0; k < NREG; k++) begin
                    if (cnt_q == CW'(k)) begin
                        w_mem_wdata = work_q[k];
                    end
                end
                if (cnt_q == CW'(NREG - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    depth_d = depth_q + DW'(1);
`ifdef RF_CTX_KEEP_EN
                    work_d  = work_q;
`else
                    for (int k = 0; k < NREG; k++) begin
                        work_d[k] = '0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RESTORE: begin
                // Address k issued at cnt=k; its data lands one cycle later.
                w_mem_re = (cnt_q < CW'(NREG));
                for (int k = 0; k < NREG; k++) begin
                    if (cnt_q == CW'(k + 1)) begin
                        work_d[k] = mem_rdata_q;
                    end
                end
                if (cnt_q == CW'(NREG)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    depth_d = depth_q - DW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            depth_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int k = 0; k < NREG; k++) begin
                work_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            depth_q <= depth_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            for (int k = 0; k < NREG; k++) begin
                work_q[k] <= work_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            mem[w_mem_addr] <= w_mem_wdata;
        end
        if (w_mem_re) begin
            mem_rdata_q <= mem[w_mem_addr];
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_f_ctx.sv
`default_nettype none
// Randomised and directed bench for reg_f_ctx against a frame-level model
// (register array plus stack of frame arrays) checked every cycle.
module tb_reg_f_ctx;
    localparam int WIDTH       = 8;
    localparam int NUM_WORK    = 8;
    localparam int STACK_DEPTH = 8;
    localparam int SIZE        = NUM_WORK + 3;
    localparam int NREG        = NUM_WORK + 1;
    localparam int AW          = $clog2(SIZE);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_f_ctx_if #(.WIDTH(WIDTH), .NUM_WORK(NUM_WORK), .STACK_DEPTH(STACK_DEPTH)) bus ();

    reg_f_ctx #(.WIDTH(WIDTH), .NUM_WORK(NUM_WORK), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Model: op 0=idle, 1=save, 2=restore; ph = cycles elapsed since accept.
    logic [WIDTH-1:0] m_reg [NREG];
    logic [WIDTH-1:0] m_stk [STACK_DEPTH][NREG];
    int m_depth = 0;
    int m_op    = 0;
    int m_ph    = 0;
    bit m_done  = 1'b0;
    bit m_ovf   = 1'b0;
    bit m_unf   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] mread(input logic [AW-1:0] a);
        if (a == AW'(0)) return '0;
        if (a == AW'(1)) return '1;
        if (int'(a) < SIZE) return m_reg[int'(a) - 2];
        return '0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_depth = 0; m_op = 0; m_ph = 0;
            m_done = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            for (int k = 0; k < NREG; k++) m_reg[k] = '0;
        end else begin
            m_done = 1'b0;
            if (m_op == 0) begin
                if (bus.rf_data_we && int'(bus.rf_addr_wr) >= 2 && int'(bus.rf_addr_wr) < SIZE)
                    m_reg[int'(bus.rf_addr_wr) - 2] = bus.rf_data_in;
                if (bus.rf_ctx_push && !bus.rf_ctx_pop) begin
                    if (m_depth == STACK_DEPTH) m_ovf = 1'b1;
                    else begin m_op = 1; m_ph = 0; end
                end else if (bus.rf_ctx_pop && !bus.rf_ctx_push) begin
                    if (m_depth == 0) m_unf = 1'b1;
                    else begin m_op = 2; m_ph = 0; end
                end
            end else begin
                m_ph++;
                if (m_op == 1) begin
                    if (m_ph == NREG) begin
                        for (int k = 0; k < NREG; k++) begin
                            m_stk[m_depth][k] = m_reg[k];
                            m_reg[k] = '0;
                        end
                        m_depth++; m_done = 1'b1; m_op = 0;
                    end
                end else begin
                    if (m_ph >= 2) m_reg[m_ph - 2] = m_stk[m_depth - 1][m_ph - 2];
                    if (m_ph == NREG + 1) begin
                        m_depth--; m_done = 1'b1; m_op = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", 32'(bus.rf_ctx_busy), 32'(m_op != 0));
            chk("done", 32'(bus.rf_ctx_done), 32'(m_done));
            chk("depth", 32'(bus.rf_ctx_depth), 32'(m_depth));
            chk("overflow", 32'(bus.rf_ctx_overflow), 32'(m_ovf));
            chk("underflow", 32'(bus.rf_ctx_underflow), 32'(m_unf));
            chk("rd1", 32'(bus.rf_data_out1), 32'(mread(bus.rf_addr_r1)));
            chk("rd2", 32'(bus.rf_data_out2), 32'(mread(bus.rf_addr_r2)));
            chk("acc_zero", 32'(bus.rf_acc_zero),
                32'((m_reg[0] == '0) || (bus.rf_data_we && m_op == 0 &&
                    bus.rf_addr_wr == AW'(2) && bus.rf_data_in == '0)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        while (bus.rf_ctx_busy && n < 40) begin
            n++;
            cyc();
        end
        if (n >= 40) chk({nm, "_timeout"}, 32'(bus.rf_ctx_busy), 32'd0);
    endtask

    task automatic wr(input int a, input logic [WIDTH-1:0] d);
        bus.rf_data_we = 1'b1;
        bus.rf_addr_wr = AW'(a);
        bus.rf_data_in = d;
        cyc();
        bus.rf_data_we = 1'b0;
    endtask

    task automatic req(input bit push, input bit pop);
        bus.rf_ctx_push = push;
        bus.rf_ctx_pop  = pop;
        cyc();
        bus.rf_ctx_push = 1'b0;
        bus.rf_ctx_pop  = 1'b0;
    endtask

    task automatic rdchk(input string nm, input int a, input logic [WIDTH-1:0] exp);
        bus.rf_addr_r1 = AW'(a);
        #1;
        chk(nm, 32'(bus.rf_data_out1), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.rf_addr_r1 = '0; bus.rf_addr_r2 = '0; bus.rf_addr_wr = '0;
        bus.rf_data_we = 1'b0; bus.rf_data_in = '0;
        bus.rf_ctx_push = 1'b0; bus.rf_ctx_pop = 1'b0;
        rst = 1'b1;
        cyc(); cyc();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_busy", 32'(bus.rf_ctx_busy), 32'd0);
        chk("rst_depth", 32'(bus.rf_ctx_depth), 32'd0);
        chk("rst_acc_zero", 32'(bus.rf_acc_zero), 32'd1);

        // Simultaneous push+pop: ignored, no flags
        req(1'b1, 1'b1);
        chk("pushpop_busy", 32'(bus.rf_ctx_busy), 32'd0);
        chk("pushpop_ovf", 32'(bus.rf_ctx_overflow), 32'd0);
        chk("pushpop_unf", 32'(bus.rf_ctx_underflow), 32'd0);

        for (int k = 0; k < NREG; k++) wr(k + 2, WIDTH'((k + 1) * 'h11));
        req(1'b1, 1'b0);
        wait_idle("save1", n);
        chk("save1_busy_cycles", 32'(n), 32'd9);
        chk("save1_done", 32'(bus.rf_ctx_done), 32'd1);
        chk("save1_depth", 32'(bus.rf_ctx_depth), 32'd1);
        chk("save1_acc_zero", 32'(bus.rf_acc_zero), 32'd1);
        for (int k = 0; k < NREG; k++) begin
            cyc();
            rdchk("save1_cleared", k + 2, 8'h00);
        end

        wr(2, 8'h5A);
        rdchk("acc_5a", 2, 8'h5A);
        req(1'b0, 1'b1);
        wait_idle("restore1", n);
        chk("restore1_busy_cycles", 32'(n), 32'd10);
        chk("restore1_done", 32'(bus.rf_ctx_done), 32'd1);
        chk("restore1_depth", 32'(bus.rf_ctx_depth), 32'd0);
        chk("restore1_acc_zero", 32'(bus.rf_acc_zero), 32'd0);
        for (int k = 0; k < NREG; k++) begin
            cyc();
            rdchk("restore1_val", k + 2, WIDTH'((k + 1) * 'h11));
        end

        // Zero-flag bypass while idle, then dropped write while busy
        wr(2, 8'h07);
        bus.rf_data_we = 1'b1; bus.rf_addr_wr = AW'(2); bus.rf_data_in = 8'h00;
        #1;
        chk("bypass_zero", 32'(bus.rf_acc_zero), 32'd1);
        cyc();
        bus.rf_data_we = 1'b0;
        wr(2, 8'h07);
        req(1'b1, 1'b0);
        bus.rf_data_we = 1'b1; bus.rf_addr_wr = AW'(2); bus.rf_data_in = 8'h00;
        #1;
        chk("busy_no_bypass", 32'(bus.rf_acc_zero), 32'd0);
        cyc();
        bus.rf_data_we = 1'b0;
        wait_idle("save2", n);
        req(1'b0, 1'b1);
        wait_idle("restore2", n);
        rdchk("busy_write_dropped", 2, 8'h07);

        // Fill the stack, overflow, then unwind LIFO
        for (int i = 0; i < STACK_DEPTH; i++) begin
            wr(2, WIDTH'('h20 + i));
            wr(3, WIDTH'(i));
            req(1'b1, 1'b0);
            wait_idle("fill", n);
        end
        chk("full_depth", 32'(bus.rf_ctx_depth), 32'd8);
        req(1'b1, 1'b0);
        chk("overflow_flag", 32'(bus.rf_ctx_overflow), 32'd1);
        chk("overflow_busy", 32'(bus.rf_ctx_busy), 32'd0);
        chk("overflow_depth", 32'(bus.rf_ctx_depth), 32'd8);
        for (int j = 0; j < STACK_DEPTH; j++) begin
            req(1'b0, 1'b1);
            wait_idle("unwind", n);
            rdchk("lifo_r2", 2, WIDTH'('h27 - j));
        end
        req(1'b0, 1'b1);
        chk("underflow_flag", 32'(bus.rf_ctx_underflow), 32'd1);
        rdchk("underflow_r2", 2, 8'h20);

        // Reset in the middle of a save
        req(1'b1, 1'b0);
        cyc(); cyc(); cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_busy", 32'(bus.rf_ctx_busy), 32'd0);
        chk("midrst_depth", 32'(bus.rf_ctx_depth), 32'd0);
        rdchk("midrst_r2", 2, 8'h00);
        wr(0, 8'h33);
        wr(1, 8'h44);
        rdchk("r0_const", 0, 8'h00);
        rdchk("r1_const", 1, 8'hFF);

        // Randomised traffic
        for (int c = 0; c < 5000; c++) begin
            rst = ($urandom_range(0, 799) == 0);
            bus.rf_data_we = 1'($urandom);
            bus.rf_addr_wr = ($urandom_range(0, 3) == 0) ? AW'(2) : AW'($urandom);
            bus.rf_data_in = ($urandom_range(0, 5) == 0) ? '0 : WIDTH'($urandom);
            bus.rf_ctx_push = ($urandom_range(0, 9) == 0);
            bus.rf_ctx_pop  = ($urandom_range(0, 10) == 0);
            bus.rf_addr_r1 = AW'($urandom);
            bus.rf_addr_r2 = AW'($urandom);
            cyc();
        end
        rst = 1'b0;
        bus.rf_data_we = 1'b0; bus.rf_ctx_push = 1'b0; bus.rf_ctx_pop = 1'b0;
        cyc(); cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
